mem_access_unit: RTL and testbench

Load/store requester that sits between the MEM pipeline stage and the byte-addressed 64 KiB data SRAM. It accepts one load or store per handshake, drives the SRAM's 4-bit byte-lane write enable, address and write data, and captures the SRAM's combinational read data. It returns a registered response: zero- or sign-extended load data, plus an error flag for illegal or wrapping accesses.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store requester for a byte-addressed
// SRAM. A request is latched on accept and drives the SRAM for one ACCESS
// cycle. The extended load data (or the error flag) is then registered and held
// in RESP until the consumer takes it.

// One SRAM byte lane: decides whether this lane is covered by the access size
// and steers the matching byte of store data onto it.
module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] i_size,
  input  logic       i_wr,
  input  logic [7:0] i_wbyte,
  output logic       o_we,
  output logic [7:0] o_wbyte
);
  logic w_cov;

  // lane coverage: byte -> lane 0, half -> lanes 0..1, word -> all, 11 -> none
  always_comb begin
    case (i_size)
      2'b00:   w_cov = (LANE == 0);
      2'b01:   w_cov = (LANE < 2);
      2'b10:   w_cov = 1'b1;
      default: w_cov = 1'b0;
    endcase
  end

  assign o_we    = i_wr && w_cov;
  assign o_wbyte = w_cov ? i_wbyte : 8'h00;
endmodule

module mem_access_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                          r_state;
  state_t                          w_next;
  req_t                            r_req;
  logic [31:0]                     r_rsp_rdata;
  logic                            r_rsp_err;
  logic                            w_accept;
  logic                            w_access;
  logic                            w_store;
  logic                            w_err;
  logic [2:0]                      w_span;
  logic [ADDR_W:0]                 w_end;
  logic [31:0]                     w_load;
  logic [NUM_LANES-1:0][7:0]       w_wdata;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state: ACCESS is always a single cycle; RESP may chain directly into
  // the next ACCESS when a new request is accepted on the retiring edge
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = w_accept ? S_ACCESS : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs; req_ready is gated by rst_n so it drops as soon as reset asserts
  always_comb begin
    req_ready = rst_n && (r_state == S_IDLE || (r_state == S_RESP && rsp_ready));
    rsp_valid = (r_state == S_RESP);
    w_access  = (r_state == S_ACCESS);
  end

  assign w_accept = req_valid && req_ready;

  // request registers load on accept and keep driving the SRAM afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_req <= '0;
    else if (w_accept) r_req <= '{req_we, req_size, req_unsigned, req_addr, req_wdata};
  end

  // last byte touched = addr + nbytes - 1; one extra bit catches the wrap
  always_comb begin
    case (r_req.size)
      2'b00:   w_span = 3'd0;
      2'b01:   w_span = 3'd1;
      default: w_span = 3'd3;
    endcase
  end

  assign w_end   = {1'b0, r_req.addr} + {{(ADDR_W-2){1'b0}}, w_span};
  assign w_err   = (r_req.size == 2'b11) || w_end[ADDR_W];
  assign w_store = w_access && r_req.we && !w_err;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_access_lane #(.LANE(g)) u_lane (
      .i_size  (r_req.size),
      .i_wr    (w_store),
      .i_wbyte (r_req.wdata[8*g +: 8]),
      .o_we    (mem_w_en[g]),
      .o_wbyte (w_wdata[g])
    );
  end

  assign mem_address    = r_req.addr;
  assign mem_write_data = w_wdata;

  // load extension; stores and errored requests return zero
  always_comb begin
    w_load = 32'h0;
    if (!r_req.we && !w_err) begin
      case (r_req.size)
        2'b00:   w_load = {{24{mem_read_data[7]  && !r_req.uns}}, mem_read_data[7:0]};
        2'b01:   w_load = {{16{mem_read_data[15] && !r_req.uns}}, mem_read_data[15:0]};
        default: w_load = mem_read_data;
      endcase
    end
  end

  // response registers capture on the closing edge of ACCESS, held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else if (w_access) begin
      r_rsp_rdata <= w_load;
      r_rsp_err   <= w_err;
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: SRAM fixture, a transaction-level reference model
// checked every cycle, and directed vectors with literal expectations.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  mem_w_en;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;

  bit [7:0] sram [65536];
  bit [7:0] refm [65536];

  mem_access_unit #(.ADDR_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_w_en       (mem_w_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // SRAM fixture: combinational read, byte-lane synchronous write
  always_comb mem_read_data = {sram[mem_address + 16'd3], sram[mem_address + 16'd2],
                               sram[mem_address + 16'd1], sram[mem_address]};

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_w_en[i]) sram[mem_address + 16'(i)] <= mem_write_data[8*i +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nb_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
  endfunction

  // Reference model: one transaction at a time. Accept -> one access cycle ->
  // response held until taken. Memory effects applied to refm at access time.
  initial begin : model
    bit          m_acc, m_rsp, m_we, m_uns, err, exp_ready;
    logic [1:0]  m_sz;
    logic [15:0] m_addr;
    logic [31:0] m_wd, m_wdata_raw, m_rdata, v;
    logic        m_err;
    logic [3:0]  exp_wen;
    int          nb, a;
    m_acc = 0; m_rsp = 0; m_we = 0; m_uns = 0; m_sz = 0; m_addr = 0;
    m_wd = 0; m_wdata_raw = 0; m_rdata = 0; m_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst mem_w_en", mem_w_en, 0);
        chk("rst mem_address", mem_address, 0);
        chk("rst mem_write_data", mem_write_data, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        chk("rst rsp_err", rsp_err, 0);
        m_acc = 0; m_rsp = 0; m_addr = 0; m_wd = 0;
      end else begin
        exp_wen = 4'h0;
        v = 32'h0;
        err = 0;
        if (m_acc) begin
          nb  = nb_of(m_sz);
          a   = int'(m_addr);
          err = (m_sz == 2'd3) || (a + nb > 65536);
          if (m_we && !err) begin
            exp_wen = 4'((1 << nb) - 1);
            for (int i = 0; i < nb; i++) refm[a + i] = m_wdata_raw[8*i +: 8];
          end else if (!m_we && !err) begin
            if (nb == 1) begin
              v = 32'(refm[a]);
              if (!m_uns && v >= 128) v = v + 32'hFFFFFF00;
            end else if (nb == 2) begin
              v = 32'(refm[a]) + (32'(refm[a+1]) << 8);
              if (!m_uns && v >= 32768) v = v + 32'hFFFF0000;
            end else begin
              v = 32'(refm[a]) + (32'(refm[a+1]) << 8) + (32'(refm[a+2]) << 16)
                + (32'(refm[a+3]) << 24);
            end
          end
        end
        chk("mem_w_en", mem_w_en, exp_wen);
        chk("mem_address", mem_address, m_addr);
        chk("mem_write_data", mem_write_data, m_wd);
        chk("rsp_valid", rsp_valid, m_rsp);
        if (m_rsp) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_err", rsp_err, m_err);
        end
        exp_ready = !m_acc && (!m_rsp || rsp_ready);
        chk("req_ready", req_ready, exp_ready);
        if (m_rsp && rsp_ready) m_rsp = 0;
        if (m_acc) begin
          m_rsp = 1; m_rdata = v; m_err = err;
        end
        m_acc = req_valid && exp_ready;
        if (m_acc) begin
          m_we = req_we; m_sz = req_size; m_uns = req_unsigned;
          m_addr = req_addr; m_wdata_raw = req_wdata;
          case (req_size)
            2'd0:    m_wd = req_wdata & 32'h000000FF;
            2'd1:    m_wd = req_wdata & 32'h0000FFFF;
            2'd2:    m_wd = req_wdata;
            default: m_wd = 32'h0;
          endcase
        end
      end
    end
  end

  // issue one request with rsp_ready=1; report write enables/data seen and the response
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output logic [3:0] wen, output logic [31:0] wdat);
    bit got;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    chk("accept timeout", got, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd = 0; er = 0; wen = 0; wdat = 0; got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_w_en != 4'h0) begin wen = wen | mem_w_en; wdat = mem_write_data; end
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; got = 1; break; end
    end
    chk("response timeout", got, 1);
    @(posedge clk); #1;
  endtask

  task automatic tx(input string name, input logic we, input logic [1:0] sz,
                    input logic uns, input logic [15:0] a, input logic [31:0] wd,
                    input logic [31:0] e_rd, input logic e_er,
                    input logic [3:0] e_wen, input logic [31:0] e_wdat);
    logic [31:0] rd, wdat;
    logic        er;
    logic [3:0]  wen;
    do_req(we, sz, uns, a, wd, rd, er, wen, wdat);
    chk({name, " rdata"}, rd, e_rd);
    chk({name, " err"}, er, e_er);
    chk({name, " w_en"}, wen, e_wen);
    chk({name, " wdata"}, wdat, e_wdat);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready literal", req_ready, 0);
    chk("reset rsp_valid literal", rsp_valid, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // word round trip
    tx("SW 1000", 1, 2'd2, 0, 16'h1000, 32'hDEADBEEF, 32'h0, 0, 4'hF, 32'hDEADBEEF);
    tx("LW 1000", 0, 2'd2, 0, 16'h1000, 32'h0, 32'hDEADBEEF, 0, 4'h0, 32'h0);
    // byte store into a known word
    tx("SW 2000", 1, 2'd2, 0, 16'h2000, 32'h55667788, 32'h0, 0, 4'hF, 32'h55667788);
    tx("SB 2001", 1, 2'd0, 0, 16'h2001, 32'h123456A5, 32'h0, 0, 4'h1, 32'h000000A5);
    tx("LB 2001", 0, 2'd0, 0, 16'h2001, 32'h0, 32'hFFFFFFA5, 0, 4'h0, 32'h0);
    tx("LBU 2001", 0, 2'd0, 1, 16'h2001, 32'h0, 32'h000000A5, 0, 4'h0, 32'h0);
    tx("LBU 2002", 0, 2'd0, 1, 16'h2002, 32'h0, 32'h00000066, 0, 4'h0, 32'h0);
    tx("LW 2000", 0, 2'd2, 0, 16'h2000, 32'h0, 32'h5566A588, 0, 4'h0, 32'h0);
    // unaligned half
    tx("SH 3001", 1, 2'd1, 0, 16'h3001, 32'h00008001, 32'h0, 0, 4'h3, 32'h00008001);
    tx("LH 3001", 0, 2'd1, 0, 16'h3001, 32'h0, 32'hFFFF8001, 0, 4'h0, 32'h0);
    tx("LHU 3001", 0, 2'd1, 1, 16'h3001, 32'h0, 32'h00008001, 0, 4'h0, 32'h0);
    // errors and the top-of-memory boundary
    tx("LW FFFE", 0, 2'd2, 0, 16'hFFFE, 32'h0, 32'h0, 1, 4'h0, 32'h0);
    tx("SW FFFD", 1, 2'd2, 0, 16'hFFFD, 32'h12345678, 32'h0, 1, 4'h0, 32'h0);
    tx("size11 0100", 0, 2'd3, 0, 16'h0100, 32'h0, 32'h0, 1, 4'h0, 32'h0);
    tx("LH FFFF", 0, 2'd1, 0, 16'hFFFF, 32'h0, 32'h0, 1, 4'h0, 32'h0);
    tx("SB FFFF", 1, 2'd0, 0, 16'hFFFF, 32'hFFFFFF5A, 32'h0, 0, 4'h1, 32'h0000005A);
    tx("LBU FFFF", 0, 2'd0, 1, 16'hFFFF, 32'h0, 32'h0000005A, 0, 4'h0, 32'h0);

    // back-to-back: one accept every 2 cycles
    req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 16'h1000;
    req_valid = 1'b1; rsp_ready = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (req_valid && req_ready) cnt++;
    end
    chk("throughput accepts", cnt, 10);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;

    // backpressure: response held, next request waits
    req_we = 0; req_size = 2'd2; req_addr = 16'h2000; req_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp first accept", req_ready, 1);
    @(posedge clk); #1;
    req_addr = 16'h1000;
    @(negedge clk);
    @(negedge clk);
    chk("bp rsp_valid", rsp_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp hold valid", rsp_valid, 1);
      chk("bp hold rdata", rsp_rdata, 32'h5566A588);
      chk("bp hold ready", req_ready, 0);
      chk("bp hold w_en", mem_w_en, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp chained accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp gap valid", rsp_valid, 0);
    @(negedge clk);
    chk("bp second valid", rsp_valid, 1);
    chk("bp second rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // reset during the ACCESS cycle of a store
    tx("SW 4000", 1, 2'd2, 0, 16'h4000, 32'hCAFEF00D, 32'h0, 0, 4'hF, 32'hCAFEF00D);
    req_we = 1; req_size = 2'd2; req_addr = 16'h4000; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst-test accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst-test w_en before", mem_w_en, 4'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst-test w_en dropped", mem_w_en, 4'h0);
    chk("rst-test req_ready", req_ready, 0);
    chk("rst-test mem_address", mem_address, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst-test no rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    tx("LW 4000 after rst", 0, 2'd2, 0, 16'h4000, 32'h0, 32'hCAFEF00D, 0, 4'h0, 32'h0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
